// File: rtl/ahb3lite_sram_slave.sv
// ---------------------------------------------------------------------------
// ahb3lite_sram_slave
//   AHB-Lite single-port SRAM slave. The address phase is registered; the
//   data phase optionally inserts WAIT_STATES low cycles on HREADYOUT before
//   it completes. Writes commit on the completing edge with little-endian
//   byte lanes. Read data comes combinationally from the array, so a read
//   that follows a write to the same word sees the new value. Misaligned,
//   oversize or out-of-range transfers get the two-cycle ERROR response and
//   never touch memory. HBURST/HPROT are accepted and ignored.
//
// Ports
//   i_hclk       clock, all state on rising edge
//   i_hreset     synchronous reset, active high
//   i_hsel       slave select
//   i_haddr      byte address (word index = i_haddr[31:2])
//   i_htrans     IDLE=0 BUSY=1 NONSEQ=2 SEQ=3
//   i_hwrite     1=write 0=read
//   i_hsize      0=byte 1=half 2=word, >2 rejected with ERROR
//   i_hburst     ignored
//   i_hprot      ignored
//   i_hwdata     write data, valid in the data phase
//   i_hready     combined bus ready
//   o_hreadyout  slave ready
//   o_hresp      0=OKAY 1=ERROR
//   o_hrdata     read data, zero outside OKAY read data phases
// ---------------------------------------------------------------------------
module ahb3lite_sram_slave #(
    parameter int MEM_DEPTH   = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic        i_hclk,
    input  logic        i_hreset,
    input  logic        i_hsel,
    input  logic [31:0] i_haddr,
    input  logic [1:0]  i_htrans,
    input  logic        i_hwrite,
    input  logic [2:0]  i_hsize,
    input  logic [2:0]  i_hburst,
    input  logic [3:0]  i_hprot,
    input  logic [31:0] i_hwdata,
    input  logic        i_hready,
    output logic        o_hreadyout,
    output logic        o_hresp,
    output logic [31:0] o_hrdata
);

    localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_ERR1   = 2'd2,
        S_ERR2   = 2'd3
    } state_t;

    state_t          r_state;
    logic [3:0]      r_cnt;
    logic            r_hreadyout;
    logic            r_hresp;
    logic            r_write;
    logic [AW-1:0]   r_word;
    logic [3:0]      r_lanes;
    logic [3:0][7:0] r_mem [MEM_DEPTH];

    logic            w_accept;
    logic            w_oob;
    logic            w_err;
    logic [3:0]      w_lanes;
    logic            w_complete;
    logic            w_commit;
    logic            w_rd_phase;
    logic            w_unused;

    // Only NONSEQ/SEQ (htrans[1]) on a ready, selected bus starts a transfer.
    assign w_accept = i_hsel & i_hready & i_htrans[1];
    assign w_oob    = ({2'b00, i_haddr[31:2]} >= 32'(MEM_DEPTH));
    assign w_err    = (i_hsize > 3'd2)
                    | ((i_hsize == 3'd1) & i_haddr[0])
                    | ((i_hsize == 3'd2) & (i_haddr[1:0] != 2'b00))
                    | w_oob;

    always_comb begin
        w_lanes = 4'b0000;
        case (i_hsize)
            3'd0:    w_lanes = 4'b0001 << i_haddr[1:0];
            3'd1:    w_lanes = i_haddr[1] ? 4'b1100 : 4'b0011;
            3'd2:    w_lanes = 4'b1111;
            default: w_lanes = 4'b0000;
        endcase
    end

    // The OKAY data phase completes on the edge where the wait counter is 0.
    assign w_complete = (r_state == S_ACCESS) && (r_cnt == 4'd0);
    assign w_commit   = w_complete && r_write && !i_hreset;
    assign w_rd_phase = w_complete && !r_write;

    assign w_unused = ^{i_hburst, i_hprot, i_htrans[0]};

    // Control FSM; HREADYOUT/HRESP are registered alongside the state so
    // they describe the cycle that follows each edge.
    always_ff @(posedge i_hclk) begin
        if (i_hreset) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_hreadyout <= 1'b1;
            r_hresp     <= 1'b0;
            r_write     <= 1'b0;
            r_word      <= '0;
            r_lanes     <= 4'b0000;
        end else if (r_state == S_ERR1) begin
            r_state     <= S_ERR2;
            r_hreadyout <= 1'b1;
            r_hresp     <= 1'b1;
        end else if ((r_state == S_ACCESS) && (r_cnt != 4'd0)) begin
            r_cnt       <= r_cnt - 4'd1;
            r_hreadyout <= (r_cnt == 4'd1);
            r_hresp     <= 1'b0;
        end else if (w_accept && w_err) begin
            // IDLE, ERR2 or a completing ACCESS edge: a bad new transfer
            r_state     <= S_ERR1;
            r_cnt       <= 4'd0;
            r_hreadyout <= 1'b0;
            r_hresp     <= 1'b1;
            r_write     <= 1'b0;
        end else if (w_accept) begin
            r_state     <= S_ACCESS;
            r_cnt       <= 4'(WAIT_STATES);
            r_hreadyout <= (WAIT_STATES == 0);
            r_hresp     <= 1'b0;
            r_write     <= i_hwrite;
            r_word      <= i_haddr[AW+1:2];
            r_lanes     <= w_lanes;
        end else begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_hreadyout <= 1'b1;
            r_hresp     <= 1'b0;
            r_write     <= 1'b0;
        end
    end

    // Array is never reset; only enabled lanes of a completing write change.
    always_ff @(posedge i_hclk) begin
        if (w_commit) begin
            for (int l = 0; l < 4; l++) begin
                if (r_lanes[l]) r_mem[r_word][l] <= i_hwdata[8*l +: 8];
            end
        end
    end

    assign o_hreadyout = r_hreadyout;
    assign o_hresp     = r_hresp;
    assign o_hrdata    = w_rd_phase ? r_mem[r_word] : 32'h0;

endmodule

// File: tb/tb_ahb3lite_sram_slave.sv
// ---------------------------------------------------------------------------
// tb_ahb3lite_sram_slave
//   Three slaves (WAIT_STATES 0, 2, 3) share one bus; only the slave under
//   test is selected. Stimulus drives one bus cycle at a time and queues the
//   hand-computed HREADYOUT/HRESP/HRDATA for that cycle; a monitor pops and
//   compares on every falling edge.
// ---------------------------------------------------------------------------
module tb_ahb3lite_sram_slave;

    localparam logic [1:0] IDLE = 2'd0, NS = 2'd2, SQ = 2'd3;

    typedef struct {
        logic        rdy;
        logic        resp;
        logic [31:0] rd;
        string       nm;
    } exp_t;

    logic        clk = 1'b0;
    logic        hreset;
    logic [2:0]  hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [3:0]  hprot;
    logic [31:0] hwdata;
    logic        hready;
    logic [2:0]  w_rdy;
    logic [2:0]  w_resp;
    logic [31:0] w_rd [3];
    int          cur = 0;
    exp_t        q[$];
    int          n_chk = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    assign hready = &w_rdy;

    ahb3lite_sram_slave #(.MEM_DEPTH(1024), .WAIT_STATES(0)) u_ws0 (
        .i_hclk(clk), .i_hreset(hreset), .i_hsel(hsel[0]), .i_haddr(haddr),
        .i_htrans(htrans), .i_hwrite(hwrite), .i_hsize(hsize), .i_hburst(hburst),
        .i_hprot(hprot), .i_hwdata(hwdata), .i_hready(hready),
        .o_hreadyout(w_rdy[0]), .o_hresp(w_resp[0]), .o_hrdata(w_rd[0]));

    ahb3lite_sram_slave #(.MEM_DEPTH(1024), .WAIT_STATES(2)) u_ws2 (
        .i_hclk(clk), .i_hreset(hreset), .i_hsel(hsel[1]), .i_haddr(haddr),
        .i_htrans(htrans), .i_hwrite(hwrite), .i_hsize(hsize), .i_hburst(hburst),
        .i_hprot(hprot), .i_hwdata(hwdata), .i_hready(hready),
        .o_hreadyout(w_rdy[1]), .o_hresp(w_resp[1]), .o_hrdata(w_rd[1]));

    ahb3lite_sram_slave #(.MEM_DEPTH(1024), .WAIT_STATES(3)) u_ws3 (
        .i_hclk(clk), .i_hreset(hreset), .i_hsel(hsel[2]), .i_haddr(haddr),
        .i_htrans(htrans), .i_hwrite(hwrite), .i_hsize(hsize), .i_hburst(hburst),
        .i_hprot(hprot), .i_hwdata(hwdata), .i_hready(hready),
        .o_hreadyout(w_rdy[2]), .o_hresp(w_resp[2]), .o_hrdata(w_rd[2]));

    // One bus cycle: drive inputs, queue the expected outputs of this cycle.
    task automatic S(input logic sel, input logic [1:0] tr, input logic wr,
                     input logic [2:0] sz, input logic [31:0] ad, input logic [31:0] wd,
                     input logic erdy, input logic eresp, input logic [31:0] erd,
                     input string nm);
        exp_t e;
        hsel   = sel ? (3'b001 << cur) : 3'b000;
        htrans = tr;
        hwrite = wr;
        hsize  = sz;
        haddr  = ad;
        hwdata = wd;
        e.rdy = erdy; e.resp = eresp; e.rd = erd; e.nm = nm;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Hold one address phase across nw wait cycles of the preceding data
    // phase, then the completing cycle whose read data is prd.
    task automatic beat(input int nw, input logic [31:0] prd, input logic [1:0] tr,
                        input logic wr, input logic [2:0] sz, input logic [31:0] ad,
                        input logic [31:0] wd, input string nm);
        for (int i = 0; i < nw; i++) S(1'b1, tr, wr, sz, ad, wd, 1'b0, 1'b0, 32'h0, nm);
        S(1'b1, tr, wr, sz, ad, wd, 1'b1, 1'b0, prd, nm);
    endtask

    always @(negedge clk) begin
        if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            n_chk++;
            if (w_rdy[cur] !== e.rdy || w_resp[cur] !== e.resp || w_rd[cur] !== e.rd) begin
                n_err++;
                $display("FAIL %s: got rdy=%0b resp=%0b rdata=%08h, want rdy=%0b resp=%0b rdata=%08h",
                         e.nm, w_rdy[cur], w_resp[cur], w_rd[cur], e.rdy, e.resp, e.rd);
            end
        end
    end

    initial begin
        hreset = 1'b1; hsel = 3'b000; haddr = 32'h0; htrans = IDLE; hwrite = 1'b0;
        hsize = 3'd2; hburst = 3'd0; hprot = 4'h3; hwdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        hreset = 1'b0;

        // 1: reset state, IDLE transfer is no access
        cur = 0;
        S(1'b1, IDLE, 1'b0, 3'd2, 32'h20, 32'h0, 1'b1, 1'b0, 32'h0, "t1_rst");
        S(1'b0, IDLE, 1'b0, 3'd2, 32'h20, 32'h0, 1'b1, 1'b0, 32'h0, "t1_idle");

        // 2: zero-wait write/read, IDLE write ignored
        beat(0, 32'h0,        NS,   1'b1, 3'd2, 32'h20, 32'h0,        "t2_w20");
        beat(0, 32'h0,        NS,   1'b0, 3'd2, 32'h20, 32'h0ABBABBA, "t2_r20");
        beat(0, 32'h0ABBABBA, NS,   1'b1, 3'd2, 32'h24, 32'h0,        "t2_rd20");
        beat(0, 32'h0,        IDLE, 1'b1, 3'd2, 32'h24, 32'h11111111, "t2_idlew");
        beat(0, 32'h0,        NS,   1'b0, 3'd2, 32'h24, 32'h0ABBABBA, "t2_r24");
        beat(0, 32'h11111111, IDLE, 1'b0, 3'd2, 32'h0,  32'h0,        "t2_rd24");

        // 3: WRAP4 write burst with 2 wait states, then read-back
        cur = 1;
        hburst = 3'd2;
        beat(0, 32'h0, NS,   1'b1, 3'd2, 32'h28, 32'h0, "t3_b0");
        beat(2, 32'h0, SQ,   1'b1, 3'd2, 32'h2C, 32'd1, "t3_b1");
        beat(2, 32'h0, SQ,   1'b1, 3'd2, 32'h20, 32'd2, "t3_b2");
        beat(2, 32'h0, SQ,   1'b1, 3'd2, 32'h24, 32'd3, "t3_b3");
        hburst = 3'd0;
        beat(2, 32'h0, NS,   1'b0, 3'd2, 32'h20, 32'd4, "t3_b4");
        beat(2, 32'd3, NS,   1'b0, 3'd2, 32'h24, 32'h0, "t3_rd20");
        beat(2, 32'd4, NS,   1'b0, 3'd2, 32'h28, 32'h0, "t3_rd24");
        beat(2, 32'd1, NS,   1'b0, 3'd2, 32'h2C, 32'h0, "t3_rd28");
        beat(2, 32'd2, IDLE, 1'b0, 3'd2, 32'h0,  32'h0, "t3_rd2C");

        // 4: byte and half lanes
        cur = 0;
        beat(0, 32'h0,        NS,   1'b1, 3'd2, 32'h20, 32'h0,        "t4_w");
        beat(0, 32'h0,        NS,   1'b1, 3'd0, 32'h21, 32'h0ABBABBA, "t4_wb");
        beat(0, 32'h0,        NS,   1'b0, 3'd2, 32'h20, 32'h00005500, "t4_r1");
        beat(0, 32'h0ABB55BA, NS,   1'b1, 3'd1, 32'h22, 32'h0,        "t4_rd1");
        beat(0, 32'h0,        NS,   1'b0, 3'd2, 32'h20, 32'hCAFE0000, "t4_r2");
        beat(0, 32'hCAFE55BA, IDLE, 1'b0, 3'd2, 32'h0,  32'h0,        "t4_rd2");

        // 5: misaligned write, out-of-range read, oversize read
        S(1'b1, NS,   1'b1, 3'd2, 32'h22,   32'h0,        1'b1, 1'b0, 32'h0,        "t5_wmis");
        S(1'b1, IDLE, 1'b0, 3'd2, 32'h0,    32'hFFFFFFFF, 1'b0, 1'b1, 32'h0,        "t5_e1");
        S(1'b1, IDLE, 1'b0, 3'd2, 32'h0,    32'h0,        1'b1, 1'b1, 32'h0,        "t5_e2");
        S(1'b1, NS,   1'b0, 3'd2, 32'h20,   32'h0,        1'b1, 1'b0, 32'h0,        "t5_idle");
        S(1'b1, NS,   1'b0, 3'd2, 32'h1000, 32'h0,        1'b1, 1'b0, 32'hCAFE55BA, "t5_r20");
        S(1'b1, IDLE, 1'b0, 3'd2, 32'h0,    32'h0,        1'b0, 1'b1, 32'h0,        "t5_oob1");
        S(1'b1, NS,   1'b0, 3'd3, 32'h20,   32'h0,        1'b1, 1'b1, 32'h0,        "t5_oob2");
        S(1'b1, IDLE, 1'b0, 3'd2, 32'h0,    32'h0,        1'b0, 1'b1, 32'h0,        "t5_sz1");
        S(1'b1, IDLE, 1'b0, 3'd2, 32'h0,    32'h0,        1'b1, 1'b1, 32'h0,        "t5_sz2");
        S(1'b1, IDLE, 1'b0, 3'd2, 32'h0,    32'h0,        1'b1, 1'b0, 32'h0,        "t5_done");

        // 6: reset in the 2nd wait cycle drops the write
        cur = 2;
        beat(0, 32'h0, NS,   1'b1, 3'd2, 32'h30, 32'h0,        "t6_pre");
        beat(3, 32'h0, IDLE, 1'b0, 3'd2, 32'h0,  32'h12345678, "t6_prew");
        S(1'b1, NS,   1'b1, 3'd2, 32'h30, 32'h0,        1'b1, 1'b0, 32'h0, "t6_acc");
        S(1'b1, IDLE, 1'b0, 3'd2, 32'h0,  32'hDEADBEEF, 1'b0, 1'b0, 32'h0, "t6_w1");
        hreset = 1'b1;
        S(1'b1, IDLE, 1'b0, 3'd2, 32'h0,  32'hDEADBEEF, 1'b0, 1'b0, 32'h0, "t6_w2");
        hreset = 1'b0;
        S(1'b1, IDLE, 1'b0, 3'd2, 32'h0,  32'hDEADBEEF, 1'b1, 1'b0, 32'h0, "t6_rst");
        beat(0, 32'h0,        NS,   1'b0, 3'd2, 32'h30, 32'h0, "t6_rd");
        beat(3, 32'h12345678, IDLE, 1'b0, 3'd2, 32'h0,  32'h0, "t6_rdd");
        beat(0, 32'h0,        IDLE, 1'b0, 3'd2, 32'h0,  32'h0, "t6_end");

        repeat (3) @(negedge clk);
        if (q.size() != 0) begin
            $display("FAIL drain: got %0d queued, want 0", q.size());
            $fatal(1, "scoreboard not drained");
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/ahb3lite_sram_slave.md
Name: ahb3lite_sram_slave

Overview:
AHB-Lite single-port SRAM slave. It sits directly downstream of the interface transfer tasks and the test programs, and is the target that all write/read smoke tests exercise. It implements the pipelined address/data phases, programmable wait states, little-endian byte lanes and the two-cycle ERROR response. HBURST and HPROT are accepted but ignored; the master computes every beat address, including wrap addresses.

Parameters:
MEM_DEPTH, 1024, number of 32-bit words; word index = HADDR[31:2].
WAIT_STATES, 0, cycles HREADYOUT is held low at the start of every OKAY data phase (0..15).

Ports:
HCLK       in   1   clock; all state updates on rising edge
HRESET     in   1   synchronous reset, active-high
HSEL       in   1   slave select
HADDR      in   32  byte address
HTRANS     in   2   IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
HWRITE     in   1   1=write, 0=read
HSIZE      in   3   0=byte, 1=half, 2=word; >2 unsupported
HBURST     in   3   ignored
HPROT      in   4   ignored
HWDATA     in   32  write data, valid in data phase
HREADY     in   1   bus ready (combined HREADYOUT of all slaves)
HREADYOUT  out  1   slave ready
HRESP      out  1   0=OKAY, 1=ERROR
HRDATA     out  32  read data

Behaviour:
- Accept: address phase sampled on an edge where HSEL & HREADY & HTRANS[1]. The slave registers addr, write, size and lane mask.
- IDLE/BUSY, HSEL=0 or HREADY=0: no access is captured and memory is untouched. If no data phase is pending, HREADYOUT=1 and HRESP=0 (zero-wait OKAY).
- Error check at accept. Any of these gives an error:
  - HSIZE>2
  - HSIZE=1 with HADDR[0]=1
  - HSIZE=2 with HADDR[1:0]!=0
  - HADDR[31:2] >= MEM_DEPTH
- States:
  - IDLE: HREADYOUT=1, HRESP=0. An OKAY accept goes to ACCESS; an error accept goes to ERR1.
  - ACCESS: a counter loads WAIT_STATES at accept.
    - While count>0: HREADYOUT=0, HRESP=0, count decrements.
    - At count=0: HREADYOUT=1 and the data phase completes on that edge.
    - On the completing edge, a new accept goes to ACCESS (counter reloaded) or ERR1; otherwise the state goes to IDLE.
  - ERR1: HREADYOUT=0, HRESP=1; always goes to ERR2.
  - ERR2: HREADYOUT=1, HRESP=1. The master may issue the next address phase here. Accept is evaluated as in IDLE, otherwise the state goes to IDLE.
- Write: committed only on the completing edge of an OKAY write data phase. Only the enabled byte lanes of HWDATA are written, little-endian:
  - byte: lane = addr[1:0]
  - half: lanes {addr[1],0} and {addr[1],1}
  - word: all 4 lanes
- Read: during an OKAY read data phase, HRDATA = mem[word] combinationally, so the value reflects any write committed on an earlier edge.
  - Back-to-back write A then read A returns the new data with no hazard.
  - All 32 bits are driven regardless of HSIZE.
- HRDATA = 0 outside read data phases, including wait cycles and error cycles.
- Error phases never touch memory.
- Reset: on an edge with HRESET=1:
  - state=IDLE, count=0, HREADYOUT=1, HRESP=0, HRDATA=0.
  - A pending write is dropped.
  - Memory contents are not cleared.
  - Reset mid-wait or mid-error aborts the transfer; the next cycle is a clean IDLE.
- HRESET has priority over every accept.

Test Plan:
1. Assert HRESET for 2 cycles, then release -> HREADYOUT=1, HRESP=0, HRDATA=0; a read of any address with HTRANS=IDLE gives OKAY, no access.
2. Zero-wait memory access (WAIT_STATES=0):
   - NONSEQ word write 0x0ABBABBA to 0x20, then NONSEQ read 0x20 -> HRDATA=0x0ABBABBA in the cycle after the read address phase, HREADYOUT never low.
   - Then write 0x11111111 to 0x24, then issue an HTRANS=IDLE write of 0x0ABBABBA to 0x24, then read 0x24 -> 0x11111111 (the IDLE write is ignored).
3. WRAP4 write burst, back-to-back, with WAIT_STATES=2:
   - Beats: NONSEQ 0x28 data 1, SEQ 0x2C data 2, SEQ 0x20 data 3, SEQ 0x24 data 4.
   - Each data phase shows HREADYOUT low for 2 cycles, then high.
   - Read-back 0x20..0x2C -> 3, 4, 1, 2.
4. Word 0x0ABBABBA at 0x20, then byte write at 0x21 with HWDATA 0x00005500 -> read gives 0x0ABB55BA. Half write at 0x22 with HWDATA 0xCAFE0000 -> read gives 0xCAFE55BA.
5. Error responses:
   - Word write at 0x22 -> HREADYOUT=0/HRESP=1, then HREADYOUT=1/HRESP=1, then IDLE OKAY; word 0x20 unchanged.
   - Read at 4*MEM_DEPTH and HSIZE=3 each produce the same 2-cycle error with HRDATA=0.
6. WAIT_STATES=3, NONSEQ write 0xDEADBEEF to 0x30, assert HRESET in the 2nd wait cycle -> next cycle HREADYOUT=1, HRESP=0; read 0x30 returns its pre-write value.
